// File: rtl/dmem_responder.sv
// +------------------------------------------------------------------------+
// | dmem_responder                                                         |
// | MEM-stage data-memory responder: word-organised RAM with wait states,  |
// | load formatting, store byte enables and pipeline stall generation.     |
// | RAM is zero-initialised at time zero; reset never alters RAM.          |
// | Revision: 1.1                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = "dmem.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        access_err_o
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_illegal;
    logic               w_done;
    logic               w_stall;
    logic               w_complete;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [31:0]        w_wmask;
    logic [31:0]        w_wlane;
    logic               w_unused_addr;

    assign w_req         = mem_read_i | mem_write_i;
    assign w_idx         = addr_i[c_IDX_W+1:2];
    assign w_unused_addr = ^{addr_i[31:c_IDX_W+2]};
    assign w_rword       = r_mem[w_idx];

    always_comb begin
        w_illegal = 1'b0;
        if (w_req) begin
            if (mem_read_i && mem_write_i)
                w_illegal = 1'b1;
            case (funct3_i)
                c_F3_B, c_F3_BU: ;
                c_F3_H, c_F3_HU: if (addr_i[0]) w_illegal = 1'b1;
                c_F3_W:          if (addr_i[1:0] != 2'b00) w_illegal = 1'b1;
                default:         w_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_done  = 1'b0;
        w_stall = 1'b0;
        if (w_illegal) begin
            w_done = 1'b1;
        end else if (w_req) begin
            if (r_state == c_S_IDLE) begin
                if (WAIT_CYCLES == 0) w_done  = 1'b1;
                else                  w_stall = 1'b1;
            end else if (r_cnt >= c_WAIT) begin
                w_done = 1'b1;
            end else begin
                w_stall = 1'b1;
            end
        end
    end

    assign w_complete = w_done & ~w_illegal;
    assign w_wr_en    = w_complete & mem_write_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else if (w_illegal) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_req && (WAIT_CYCLES != 0)) begin
                        r_state <= c_S_WAIT;
                        r_cnt   <= 4'd1;
                    end
                end
                c_S_WAIT: begin
                    if (!w_req || (r_cnt >= c_WAIT)) begin
                        r_state <= c_S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign w_byte = w_rword[{addr_i[1:0], 3'b000} +: 8];
    assign w_half = addr_i[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = 32'd0;
        case (funct3_i)
            c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_load = w_rword;
            c_F3_BU: w_load = {24'd0, w_byte};
            c_F3_HU: w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_wmask = 32'd0;
        w_wlane = 32'd0;
        case (funct3_i[1:0])
            2'b00: begin
                w_wlane = {4{wdata_i[7:0]}};
                w_wmask = 32'h0000_00FF << {addr_i[1:0], 3'b000};
            end
            2'b01: begin
                w_wlane = {2{wdata_i[15:0]}};
                w_wmask = addr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: begin
                w_wlane = wdata_i;
                w_wmask = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_idx] <= (w_rword & ~w_wmask) | (w_wlane & w_wmask);
    end

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++)
            r_mem[i] = 32'd0;
    end

    assign rdata_o      = (w_complete && mem_read_i) ? w_load : 32'd0;
    assign done_o       = w_done;
    assign stall_o      = w_stall;
    assign access_err_o = w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +------------------------------------------------------------------------+
// | tb_dmem_responder                                                      |
// | Directed self-checking bench: WAIT_CYCLES=2 and WAIT_CYCLES=0 builds.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

   localparam logic [2:0] c_B = 3'b000, c_H = 3'b001, c_W = 3'b010,
                          c_BU = 3'b100, c_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata;
   logic        done, stall, err;

   logic        z_read, z_write;
   logic [2:0]  z_funct3;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic        z_done, z_stall, z_err;

   int n_checks = 0;
   int n_pass   = 0;
   int z_stall_seen = 0;
   int excl_bad = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
      .done_o(done), .stall_o(stall), .access_err_o(err));

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_read_i(z_read), .mem_write_i(z_write),
      .funct3_i(z_funct3), .addr_i(z_addr), .wdata_i(z_wdata), .rdata_o(z_rdata),
      .done_o(z_done), .stall_o(z_stall), .access_err_o(z_err));

   always @(negedge clk) begin
      if (z_stall) z_stall_seen++;
      if (stall && (done || err)) excl_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Drives one request on the WAIT_CYCLES=2 DUT until done_o (bounded).
   task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdv, output int lat, output int stalls);
      bit fin;
      fin = 1'b0; lat = -1; stalls = 0; rdv = 32'd0;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      for (int c = 0; c < 20 && !fin; c++) begin
         @(negedge clk);
         if (done) begin
            fin = 1'b1; lat = c; rdv = rdata;
         end else if (stall) begin
            stalls++;
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input string tag);
      logic [31:0] rdv; int lat, st;
      acc(1'b0, 1'b1, f3, a, wd, rdv, lat, st);
      check({tag, "_lat"}, 32'(lat), 32'd2);
      check({tag, "_rdata"}, rdv, 32'd0);
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                       input string tag);
      logic [31:0] rdv; int lat, st;
      acc(1'b1, 1'b0, f3, a, 32'd0, rdv, lat, st);
      check({tag, "_lat"}, 32'(lat), 32'd2);
      check({tag, "_stalls"}, 32'(st), 32'd2);
      check(tag, rdv, exp);
   endtask

   task automatic bad(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      check({tag, "_err"},   32'(err),   32'd1);
      check({tag, "_done"},  32'(done),  32'd1);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_rdata"}, rdata,      32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic zacc(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string tag);
      z_read = rd; z_write = wr; z_funct3 = f3; z_addr = a; z_wdata = wd;
      @(negedge clk);
      check({tag, "_done"},  32'(z_done),  32'd1);
      check({tag, "_stall"}, 32'(z_stall), 32'd0);
      check({tag, "_rdata"}, z_rdata,      exp);
      @(posedge clk); #1;
      z_read = 1'b0; z_write = 1'b0;
   endtask

   initial begin
      logic [31:0] rdv; int lat, st;
      rst = 1'b1;
      mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      z_read = 0; z_write = 0; z_funct3 = 0; z_addr = 0; z_wdata = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_err",   32'(err),   32'd0);
      check("rst_rdata", rdata,      32'd0);
      @(posedge clk); #1;

      // Basic word store/load with two wait states
      acc(1'b0, 1'b1, c_W, 32'h10, 32'hDEADBEEF, rdv, lat, st);
      check("sw10_lat", 32'(lat), 32'd2);
      check("sw10_stalls", 32'(st), 32'd2);
      load(c_W, 32'h10, 32'hDEADBEEF, "lw10");

      // Byte/half formatting
      store(c_W, 32'h20, 32'h80FF7F01, "sw20");
      load(c_B,  32'h23, 32'hFFFFFF80, "lb23");
      load(c_BU, 32'h23, 32'h00000080, "lbu23");
      load(c_H,  32'h22, 32'hFFFF80FF, "lh22");
      load(c_HU, 32'h20, 32'h00007F01, "lhu20");
      store(c_B, 32'h21, 32'h000000AA, "sb21");
      load(c_W,  32'h20, 32'h80FFAA01, "lw20_after_sb");
      store(c_H, 32'h22, 32'h00001234, "sh22");
      load(c_W,  32'h20, 32'h1234AA01, "lw20_after_sh");

      // Illegal accesses
      bad(1'b1, 1'b0, c_W,    32'h06, 32'd0, "lw_mis");
      bad(1'b0, 1'b1, c_W,    32'h12, 32'd0, "sw_mis");
      bad(1'b0, 1'b1, c_H,    32'h11, 32'd0, "sh_odd");
      bad(1'b1, 1'b1, c_W,    32'h10, 32'd0, "rd_wr");
      bad(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, "f3_011");
      load(c_W, 32'h10, 32'hDEADBEEF, "lw10_after_err");

      // Flush mid-wait
      store(c_W, 32'h30, 32'hCAFEF00D, "sw30");
      mem_write = 1'b1; funct3 = c_W; addr = 32'h30; wdata = 32'h12345678;
      @(negedge clk);
      check("flush_stall0", 32'(stall), 32'd1);
      @(posedge clk); #1;
      mem_write = 1'b0;
      @(negedge clk);
      check("flush_done",  32'(done),  32'd0);
      check("flush_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      load(c_W, 32'h30, 32'hCAFEF00D, "lw30_after_flush");

      // Reset during the completing WAIT cycle
      store(c_W, 32'h40, 32'h22222222, "sw40");
      mem_write = 1'b1; funct3 = c_W; addr = 32'h40; wdata = 32'h11111111;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check("rstmid_stall", 32'(stall), 32'd0);
      check("rstmid_done",  32'(done),  32'd0);
      @(posedge clk); #1;
      load(c_W, 32'h40, 32'h22222222, "lw40_after_rst");

      // Zero-wait build and address wrap
      zacc(1'b0, 1'b1, c_W, 32'h1000, 32'hA5A5A5A5, 32'd0, "z_sw1000");
      zacc(1'b1, 1'b0, c_W, 32'h0,    32'd0, 32'hA5A5A5A5, "z_lw0");
      zacc(1'b1, 1'b0, c_B, 32'h1003, 32'd0, 32'hFFFFFFA5, "z_lb1003");
      check("z_stall_never", 32'(z_stall_seen), 32'd0);
      check("stall_exclusive", 32'(excl_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
